// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, arithmetic shift right and parallel load.
// A saturating shift counter with a done flag frames one WIDTH-bit word.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] shl, shr, rol, ror, asr;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] cnt_next;
    logic             done_next;
    logic             is_shift;

    // A single-bit register has no interior slice, so its shifted forms are built separately.
    if (WIDTH == 1) begin : g_one
        assign shl = sin_r;
        assign shr = sin_l;
        assign rol = q;
        assign ror = q;
        assign asr = q;
    end else begin : g_wide
        assign shl = {q[WIDTH-2:0], sin_r};
        assign shr = {sin_l, q[WIDTH-1:1]};
        assign rol = {q[WIDTH-2:0], q[WIDTH-1]};
        assign ror = {q[0], q[WIDTH-1:1]};
        assign asr = {q[WIDTH-1], q[WIDTH-1:1]};
    end

    always_comb begin
        q_next    = q;
        cnt_next  = shift_cnt;
        done_next = done;
        is_shift  = 1'b0;
        case (mode)
            MODE_HOLD: ;
            MODE_SHL: begin q_next = shl; is_shift = 1'b1; end
            MODE_SHR: begin q_next = shr; is_shift = 1'b1; end
            MODE_ROL: begin q_next = rol; is_shift = 1'b1; end
            MODE_ROR: begin q_next = ror; is_shift = 1'b1; end
            MODE_ASR: begin q_next = asr; is_shift = 1'b1; end
            MODE_LOAD: begin
                q_next    = d;
                cnt_next  = '0;
                done_next = 1'b0;
            end
            default: ;
        endcase
        if (is_shift) begin
            if (shift_cnt != CNT_MAX) begin
                cnt_next = shift_cnt + CNT_W'(1);
            end
            done_next = (cnt_next == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !clear_n) begin
            q         <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (en) begin
            q         <= q_next;
            shift_cnt <= cnt_next;
            done      <= done_next;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: directed steps push expected outputs,
// a negedge monitor pops and compares them against an 8-bit and a 1-bit instance.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = '0;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] q;
    logic       sout_l, sout_r;
    logic [3:0] shift_cnt;
    logic       done;

    logic       w_clear_n = 1'b1;
    logic       w_en = 1'b0;
    logic [2:0] w_mode = 3'b000;
    logic [0:0] w_d = '0;
    logic       w_sin_r = 1'b0;
    logic       w_sin_l = 1'b0;
    logic [0:0] w_q;
    logic       w_sout_l, w_sout_r;
    logic [0:0] w_cnt;
    logic       w_done;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .clear_n(clear_n), .en(en), .mode(mode),
        .d(d), .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .shift_cnt(shift_cnt), .done(done)
    );

    univ_shift_reg #(.WIDTH(1), .CNT_W(1)) dut_w1 (
        .clk(clk), .reset(reset), .clear_n(w_clear_n), .en(w_en), .mode(w_mode),
        .d(w_d), .sin_r(w_sin_r), .sin_l(w_sin_l), .q(w_q), .sout_l(w_sout_l),
        .sout_r(w_sout_r), .shift_cnt(w_cnt), .done(w_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         w1;
        int         due;
        logic [7:0] q;
        int         cnt;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: output of each step is presented one posedge after it is issued.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                logic [7:0] aq;
                int         ac;
                logic       ad, asl, asr;
                logic       esl, esr;
                e = sb.pop_front();
                if (e.w1) begin
                    aq = {7'b0, w_q}; ac = int'(w_cnt); ad = w_done;
                    asl = w_sout_l; asr = w_sout_r;
                    esl = e.q[0]; esr = e.q[0];
                end else begin
                    aq = q; ac = int'(shift_cnt); ad = done;
                    asl = sout_l; asr = sout_r;
                    esl = e.q[7]; esr = e.q[0];
                end
                vectors++;
                if (aq !== e.q || ac != e.cnt || ad !== e.done || asl !== esl || asr !== esr) begin
                    miscompares++;
                    $display("FAIL %s: got q=%h cnt=%0d done=%b sl=%b sr=%b, want q=%h cnt=%0d done=%b sl=%b sr=%b",
                             e.name, aq, ac, ad, asl, asr, e.q, e.cnt, e.done, esl, esr);
                end
            end
        end
    end

    task automatic push(input string name, input bit w1, input logic [7:0] eq, input int ec, input logic ed);
        exp_t e;
        e.name = name; e.w1 = w1; e.due = cyc + 1;
        e.q = eq; e.cnt = ec; e.done = ed;
        sb.push_back(e);
    endtask

    task automatic step(input string name, input logic rst, input logic clr_n, input logic e,
                        input logic [2:0] m, input logic [7:0] dd, input logic sr, input logic sl,
                        input logic [7:0] eq, input int ec, input logic ed);
        reset = rst; clear_n = clr_n; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
        push(name, 1'b0, eq, ec, ed);
        @(posedge clk);
        #1;
    endtask

    task automatic wstep(input string name, input logic e, input logic [2:0] m, input logic dd,
                         input logic sr, input logic sl, input logic eq, input int ec, input logic ed);
        reset = 1'b0; w_clear_n = 1'b1; w_en = e; w_mode = m; w_d = dd; w_sin_r = sr; w_sin_l = sl;
        en = 1'b0;
        push(name, 1'b1, {7'b0, eq}, ec, ed);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] shl_exp [8] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    logic [7:0] shr_exp [10] = '{8'h9E, 8'hCF, 8'hE7, 8'hF3, 8'hF9, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF};

    initial begin
        @(posedge clk);
        #1;
        // 1: reset dominates a load
        step("reset1", 1, 1, 1, 3'b101, 8'hFF, 0, 0, 8'h00, 0, 0);
        step("reset2", 1, 1, 1, 3'b101, 8'hFF, 0, 0, 8'h00, 0, 0);

        // 2: load A5, shift left x8 with zero fill
        step("load_a5", 0, 1, 1, 3'b101, 8'hA5, 0, 0, 8'hA5, 0, 0);
        for (int i = 0; i < 8; i++)
            step($sformatf("shl%0d", i + 1), 0, 1, 1, 3'b001, 8'h00, 0, 0,
                 shl_exp[i], i + 1, (i == 7));
        step("hold_done", 0, 1, 1, 3'b000, 8'h00, 0, 0, 8'h00, 8, 1);
        step("load_after_done", 0, 1, 1, 3'b101, 8'h5A, 0, 0, 8'h5A, 0, 0);

        // 3: rotates
        step("load_81", 0, 1, 1, 3'b101, 8'h81, 0, 0, 8'h81, 0, 0);
        step("ror1", 0, 1, 1, 3'b100, 8'h00, 0, 0, 8'hC0, 1, 0);
        step("rol1", 0, 1, 1, 3'b011, 8'h00, 0, 0, 8'h81, 2, 0);
        step("rol2", 0, 1, 1, 3'b011, 8'h00, 0, 0, 8'h03, 3, 0);
        step("reserved_hold", 0, 1, 1, 3'b111, 8'hFF, 1, 1, 8'h03, 3, 0);

        // 4: arithmetic shift right then enable low
        step("load_90", 0, 1, 1, 3'b101, 8'h90, 0, 0, 8'h90, 0, 0);
        step("asr1", 0, 1, 1, 3'b110, 8'h00, 0, 0, 8'hC8, 1, 0);
        step("asr2", 0, 1, 1, 3'b110, 8'h00, 0, 0, 8'hE4, 2, 0);
        step("asr3", 0, 1, 1, 3'b110, 8'h00, 0, 0, 8'hF2, 3, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("en_off%0d", i), 0, 1, 0, 3'b101 - 3'(i), 8'h11, 1, 1, 8'hF2, 3, 0);

        // 5: shift right with one fill, counter saturates
        step("load_3c", 0, 1, 1, 3'b101, 8'h3C, 0, 0, 8'h3C, 0, 0);
        for (int i = 0; i < 10; i++)
            step($sformatf("shr%0d", i + 1), 0, 1, 1, 3'b010, 8'h00, 0, 1,
                 shr_exp[i], (i < 8) ? i + 1 : 8, (i >= 7));

        // 6: clear beats load mid-word; reset mid-word
        step("load_55", 0, 1, 1, 3'b101, 8'h55, 0, 0, 8'h55, 0, 0);
        step("shl_55", 0, 1, 1, 3'b001, 8'h00, 1, 0, 8'hAB, 1, 0);
        step("shl_ab", 0, 1, 1, 3'b001, 8'h00, 0, 0, 8'h56, 2, 0);
        step("clear_mid", 0, 0, 1, 3'b101, 8'hAA, 0, 0, 8'h00, 0, 0);
        step("load_c3", 0, 1, 1, 3'b101, 8'hC3, 0, 0, 8'hC3, 0, 0);
        step("rol_c3", 0, 1, 1, 3'b011, 8'h00, 0, 0, 8'h87, 1, 0);
        step("reset_mid", 1, 1, 1, 3'b011, 8'h00, 0, 0, 8'h00, 0, 0);

        // WIDTH=1 instance
        wstep("w1_load0", 1, 3'b101, 1'b0, 0, 0, 1'b0, 0, 0);
        wstep("w1_shl", 1, 3'b001, 1'b0, 1, 0, 1'b1, 1, 1);
        wstep("w1_shr", 1, 3'b010, 1'b0, 0, 0, 1'b0, 1, 1);
        wstep("w1_load1", 1, 3'b101, 1'b1, 0, 0, 1'b1, 0, 0);
        wstep("w1_ror", 1, 3'b100, 1'b0, 0, 0, 1'b1, 1, 1);
        wstep("w1_en_off", 0, 3'b101, 1'b0, 0, 0, 1'b1, 1, 1);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
